// File: rtl/sccb_init_seq_pkg.sv
// ============================================================================
// Module  : sccb_init_seq_pkg
// Purpose : Shared states, table markers and width helper for the SCCB init sequencer.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package sccb_init_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_ISSUE     = 4'd3,
    ST_WAIT_DONE = 4'd4,
    ST_RELEASE   = 4'd5,
    ST_DELAY     = 4'd6,
    ST_DONE      = 4'd7,
    ST_ERROR     = 4'd8
  } state_t;

  localparam int          ENTRY_W         = 16;
  localparam logic [15:0] END_MARKER      = 16'hFFFF;
  localparam logic [7:0]  DELAY_REG       = 8'hFE;
  localparam int          WATCHDOG_PULSES = 128;
  localparam logic [7:0]  LAST_INDEX      = 8'hFF;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int width_for(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sccb_init_seq_if.sv
// ============================================================================
// Module  : sccb_init_seq_if
// Purpose : Request/completion bundle between the init sequencer and the SCCB controller.
// Rev     : 1.0
// ============================================================================
`default_nettype none

interface sccb_init_seq_if;
  import sccb_init_seq_pkg::*;

  logic [7:0]         ctrl_addr_o;
  logic [ENTRY_W-1:0] ctrl_data_o;
  logic               ctrl_rw_o;
  logic               ctrl_start_o;
  logic               ctrl_done_i;
  logic               ctrl_ack_error_i;

  modport master (
    output ctrl_addr_o,
    output ctrl_data_o,
    output ctrl_rw_o,
    output ctrl_start_o,
    input  ctrl_done_i,
    input  ctrl_ack_error_i
  );

  modport slave (
    input  ctrl_addr_o,
    input  ctrl_data_o,
    input  ctrl_rw_o,
    input  ctrl_start_o,
    output ctrl_done_i,
    output ctrl_ack_error_i
  );

endinterface

`default_nettype wire

// File: rtl/sccb_init_seq_clk_gen.sv
// ============================================================================
// Module  : sccb_clk_gen
// Purpose : Free-running SCCB clock divider with a strobe in the middle of each low phase.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module sccb_clk_gen
  import sccb_init_seq_pkg::*;
#(
  parameter int CLK_DIV = 250
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic sccb_clk_o,
  output logic data_pulse_o
);

  localparam int            CW      = width_for(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_MID = CW'(CLK_DIV / 2);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;

  always_comb begin
    cnt_d  = cnt_q + CW'(1);
    sclk_d = sclk_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d  = '0;
      sclk_d = ~sclk_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      sclk_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sccb_clk_o   = sclk_q;
  assign data_pulse_o = (cnt_q == CNT_MID) && !sclk_q;

endmodule

`default_nettype wire

// File: rtl/sccb_init_seq.sv
// ============================================================================
// Module  : sccb_init_seq
// Purpose : Walks a register table in ROM and issues SCCB writes, delays and retries.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module sccb_init_seq
  import sccb_init_seq_pkg::*;
#(
  parameter int         CLK_DIV   = 250,
  parameter logic [7:0] DEVICE_ID = 8'h42,
  parameter int         RETRY_MAX = 3,
  parameter int         MS_CYCLES = 50000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 go_i,
  output logic [7:0]           tbl_addr_o,
  input  logic [ENTRY_W-1:0]   tbl_data_i,
  output logic                 sccb_clk_o,
  output logic                 data_pulse_o,
  sccb_init_seq_if.master      ctrl,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic [7:0]           err_index_o
);

  localparam int            RTW       = width_for(RETRY_MAX);
  localparam logic [RTW-1:0] RETRY_LIM = RTW'(RETRY_MAX);
  localparam int            DW        = width_for(255 * MS_CYCLES);
  localparam logic [7:0]    WD_LAST   = 8'(WATCHDOG_PULSES - 1);

  state_t             state_q, state_d;
  logic [7:0]         index_q, index_d;
  logic [7:0]         addr_q, addr_d;
  logic [RTW-1:0]     retry_q, retry_d;
  logic [7:0]         wdog_q, wdog_d;
  logic [DW-1:0]      dly_q, dly_d;
  logic [ENTRY_W-1:0] data_q, data_d;
  logic               start_q, start_d;
  logic               reissue_q, reissue_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic [7:0]         err_idx_q, err_idx_d;
  logic               pulse_w;
  logic               ack_ok_w;
  logic               ack_bad_w;

  sccb_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .sccb_clk_o   (sccb_clk_o),
    .data_pulse_o (pulse_w)
  );

  // Completion is only trusted on strobe cycles; a silent controller trips the watchdog.
  always_comb begin
    ack_ok_w  = 1'b0;
    ack_bad_w = 1'b0;
    if (state_q == ST_WAIT_DONE && pulse_w) begin
      if (ctrl.ctrl_done_i) begin
        ack_ok_w  = !ctrl.ctrl_ack_error_i;
        ack_bad_w = ctrl.ctrl_ack_error_i;
      end else if (wdog_q == WD_LAST) begin
        ack_bad_w = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    addr_d    = addr_q;
    retry_d   = retry_q;
    wdog_d    = wdog_q;
    dly_d     = dly_q;
    data_d    = data_q;
    start_d   = start_q;
    reissue_d = reissue_q;
    busy_d    = busy_q;
    done_d    = done_q;
    error_d   = error_q;
    err_idx_d = err_idx_q;

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (go_i) begin
          state_d = ST_FETCH;
          index_d = '0;
          addr_d  = '0;
          retry_d = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          error_d = 1'b0;
        end
      end

      ST_FETCH: state_d = ST_DECODE;

      ST_DECODE: begin
        if (tbl_data_i == END_MARKER || index_q == LAST_INDEX) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (tbl_data_i[15:8] == DELAY_REG) begin
          if (tbl_data_i[7:0] == 8'd0) begin
            index_d = index_q + 8'd1;
            addr_d  = index_q + 8'd1;
            state_d = ST_FETCH;
          end else begin
            dly_d   = DW'(tbl_data_i[7:0]) * DW'(MS_CYCLES);
            state_d = ST_DELAY;
          end
        end else begin
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        data_d  = tbl_data_i;
        start_d = 1'b1;
        wdog_d  = '0;
        state_d = ST_WAIT_DONE;
      end

      ST_WAIT_DONE: begin
        if (pulse_w && !ctrl.ctrl_done_i && !ack_bad_w)
          wdog_d = wdog_q + 8'd1;
        if (ack_ok_w) begin
          retry_d   = '0;
          index_d   = index_q + 8'd1;
          start_d   = 1'b0;
          reissue_d = 1'b0;
          state_d   = ST_RELEASE;
        end else if (ack_bad_w) begin
          start_d = 1'b0;
          if (retry_q < RETRY_LIM) begin
            retry_d   = retry_q + RTW'(1);
            reissue_d = 1'b1;
            state_d   = ST_RELEASE;
          end else begin
            err_idx_d = index_q;
            error_d   = 1'b1;
            busy_d    = 1'b0;
            state_d   = ST_ERROR;
          end
        end
      end

      ST_RELEASE: begin
        if (pulse_w && !ctrl.ctrl_done_i) begin
          if (reissue_q) begin
            state_d = ST_ISSUE;
          end else begin
            addr_d  = index_q;
            state_d = ST_FETCH;
          end
        end
      end

      ST_DELAY: begin
        if (dly_q <= DW'(1)) begin
          dly_d   = '0;
          index_d = index_q + 8'd1;
          addr_d  = index_q + 8'd1;
          state_d = ST_FETCH;
        end else begin
          dly_d = dly_q - DW'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      index_q   <= '0;
      addr_q    <= '0;
      retry_q   <= '0;
      wdog_q    <= '0;
      dly_q     <= '0;
      data_q    <= '0;
      start_q   <= 1'b0;
      reissue_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      addr_q    <= addr_d;
      retry_q   <= retry_d;
      wdog_q    <= wdog_d;
      dly_q     <= dly_d;
      data_q    <= data_d;
      start_q   <= start_d;
      reissue_q <= reissue_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      err_idx_q <= err_idx_d;
    end
  end

  // Reset withdraws the request combinationally so the controller never sees a stale start.
  assign ctrl.ctrl_start_o = start_q & ~rst_i;
  assign ctrl.ctrl_data_o  = data_q;
  assign ctrl.ctrl_addr_o  = DEVICE_ID;
  assign ctrl.ctrl_rw_o    = 1'b1;

  assign tbl_addr_o   = addr_q;
  assign data_pulse_o = pulse_w;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign err_index_o  = err_idx_q;

endmodule

`default_nettype wire

// File: tb/tb_sccb_init_seq.sv
// ============================================================================
// Module  : tb_sccb_init_seq
// Purpose : Directed bench for the SCCB init sequencer with ROM and controller models.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_sccb_init_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go  = 1'b0;
  logic [7:0]  tbl_addr;
  logic [15:0] tbl_data;
  logic        sccb_clk, data_pulse, busy, done, error;
  logic [7:0]  err_index;

  sccb_init_seq_if bus ();

  sccb_init_seq #(
    .CLK_DIV   (4),
    .DEVICE_ID (8'h42),
    .RETRY_MAX (3),
    .MS_CYCLES (10)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .go_i         (go),
    .tbl_addr_o   (tbl_addr),
    .tbl_data_i   (tbl_data),
    .sccb_clk_o   (sccb_clk),
    .data_pulse_o (data_pulse),
    .ctrl         (bus),
    .busy_o       (busy),
    .done_o       (done),
    .error_o      (error),
    .err_index_o  (err_index)
  );

  always #5 clk = ~clk;

  // Synchronous table ROM
  logic [15:0] rom [256];
  always @(posedge clk) tbl_data <= rom[tbl_addr];

  // Controller model: answers two strobes after start, nacks one chosen entry
  logic        never_done = 1'b0;
  logic [15:0] nack_data  = 16'h0000;
  int          lat;
  always @(posedge clk) begin
    if (rst || !bus.ctrl_start_o) begin
      bus.ctrl_done_i      <= 1'b0;
      bus.ctrl_ack_error_i <= 1'b0;
      lat                  <= 0;
    end else if (!bus.ctrl_done_i && data_pulse && !never_done) begin
      if (lat == 1) begin
        bus.ctrl_done_i      <= 1'b1;
        bus.ctrl_ack_error_i <= (bus.ctrl_data_o == nack_data);
      end
      lat <= lat + 1;
    end
  end

  // Transaction log: data captured on each rising start
  logic [15:0] txn [16];
  int          n_txn = 0;
  logic        prev_start = 1'b0;
  logic        log_clr = 1'b0;
  always @(posedge clk) begin
    prev_start <= bus.ctrl_start_o;
    if (log_clr) begin
      n_txn <= 0;
    end else if (bus.ctrl_start_o && !prev_start && n_txn < 16) begin
      txn[n_txn] <= bus.ctrl_data_o;
      n_txn      <= n_txn + 1;
    end
  end

  int   total = 0;
  int   bad   = 0;
  logic clkv [40];
  logic pv   [40];
  int   f1, f2, p1, np, k;
  logic saw_start;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    log_clr = 1'b1;
    @(negedge clk);
    log_clr = 1'b0;
  endtask

  task automatic start_seq();
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_end(input int limit);
    int c;
    c = 0;
    while (!(done || error) && c < limit) begin
      @(negedge clk);
      c++;
    end
    check("end_reached", 32'(done || error), 32'd1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_sccb_clk"},  32'(sccb_clk), 32'd1);
    check({pfx, "_pulse"},     32'(data_pulse), 32'd0);
    check({pfx, "_start"},     32'(bus.ctrl_start_o), 32'd0);
    check({pfx, "_ctrl_data"}, 32'(bus.ctrl_data_o), 32'h0);
    check({pfx, "_tbl_addr"},  32'(tbl_addr), 32'h0);
    check({pfx, "_busy"},      32'(busy), 32'd0);
    check({pfx, "_done"},      32'(done), 32'd0);
    check({pfx, "_error"},     32'(error), 32'd0);
    check({pfx, "_err_index"}, 32'(err_index), 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;

    // Reset values
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    check("ctrl_addr", 32'(bus.ctrl_addr_o), 32'h42);
    check("ctrl_rw",   32'(bus.ctrl_rw_o), 32'd1);

    // Clock generator with CLK_DIV=4
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      clkv[i] = sccb_clk;
      pv[i]   = data_pulse;
    end
    f1 = -1; f2 = -1; p1 = -1; np = 0;
    for (int i = 1; i < 40; i++)
      if (clkv[i-1] && !clkv[i]) begin
        if (f1 < 0) f1 = i;
        else if (f2 < 0) f2 = i;
      end
    for (int i = 0; i < 40; i++)
      if (pv[i]) begin
        if (p1 < 0 && f1 >= 0 && i >= f1) p1 = i;
        if (f1 >= 0 && f2 >= 0 && i >= f1 && i < f2) np++;
      end
    check("first_fall",        32'(f1), 32'd3);
    check("sclk_period",       32'(f2 - f1), 32'd8);
    check("pulse_after_fall",  32'(p1 - f1), 32'd2);
    check("pulses_per_period", 32'(np), 32'd1);

    // Normal table, acked writes, stray go while busy
    rom[0] = 16'h1280; rom[1] = 16'h12FF; rom[2] = 16'hFFFF;
    clear_log();
    start_seq();
    check("run_busy", 32'(busy), 32'd1);
    check("run_done_low", 32'(done), 32'd0);
    repeat (20) @(negedge clk);
    start_seq();
    wait_end(3000);
    check("ok_done",  32'(done), 32'd1);
    check("ok_error", 32'(error), 32'd0);
    check("ok_busy",  32'(busy), 32'd0);
    check("ok_start", 32'(bus.ctrl_start_o), 32'd0);
    check("ok_ntxn",  32'(n_txn), 32'd2);
    check("ok_txn0",  32'(txn[0]), 32'h1280);
    check("ok_txn1",  32'(txn[1]), 32'h12FF);

    // Entry 1 always nacks: 1 + RETRY_MAX attempts, then error
    nack_data = 16'h12FF;
    clear_log();
    start_seq();
    check("nack_done_cleared", 32'(done), 32'd0);
    check("nack_busy", 32'(busy), 32'd1);
    wait_end(3000);
    check("nack_error",     32'(error), 32'd1);
    check("nack_done",      32'(done), 32'd0);
    check("nack_err_index", 32'(err_index), 32'd1);
    check("nack_start",     32'(bus.ctrl_start_o), 32'd0);
    check("nack_ntxn",      32'(n_txn), 32'd5);
    for (int i = 1; i < 5; i++) check($sformatf("nack_txn%0d", i), 32'(txn[i]), 32'h12FF);

    // Delay entry FE02 with MS_CYCLES=10: FETCH+DECODE+20 delay cycles to the next fetch
    nack_data = 16'h0000;
    rom[0] = 16'hFE02; rom[1] = 16'h1280; rom[2] = 16'hFFFF;
    clear_log();
    start_seq();
    check("dly_error_cleared", 32'(error), 32'd0);
    k = 1;
    saw_start = 1'b0;
    while (tbl_addr != 8'd1 && k < 100) begin
      if (bus.ctrl_start_o) saw_start = 1'b1;
      @(negedge clk);
      k++;
    end
    check("delay_cycles",   32'(k - 3), 32'd20);
    check("delay_no_start", 32'(saw_start), 32'd0);
    wait_end(3000);
    check("dly_done", 32'(done), 32'd1);
    check("dly_ntxn", 32'(n_txn), 32'd1);
    check("dly_txn0", 32'(txn[0]), 32'h1280);

    // Silent controller: zero-length delay, then watchdog-driven retries to error
    never_done = 1'b1;
    rom[0] = 16'hFE00; rom[1] = 16'h1280; rom[2] = 16'hFFFF;
    clear_log();
    start_seq();
    wait_end(6000);
    check("wd_error",     32'(error), 32'd1);
    check("wd_done",      32'(done), 32'd0);
    check("wd_err_index", 32'(err_index), 32'd1);
    check("wd_ntxn",      32'(n_txn), 32'd4);

    // Reset while waiting on the controller
    start_seq();
    k = 0;
    while (!bus.ctrl_start_o && k < 50) begin
      @(negedge clk);
      k++;
    end
    repeat (10) @(negedge clk);
    check("mid_start_high", 32'(bus.ctrl_start_o), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_start_same_cycle", 32'(bus.ctrl_start_o), 32'd0);
    @(negedge clk);
    check_reset_outputs("mid");
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("post_rst_idle_busy",  32'(busy), 32'd0);
    check("post_rst_idle_start", 32'(bus.ctrl_start_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
